// File: rtl/tone_pkg.sv
// Shared constants and note-table helpers for the polyphonic tone synth.
package tone_pkg;

    localparam int unsigned NOTE_CNT     = 21;
    localparam int unsigned NOTE_W       = 5;
    localparam int unsigned NOTE_PER_OCT = 7;

    // Integer frequency of a note: C4..B4 base table, doubled per octave.
    function automatic int unsigned note_hz(input int unsigned idx);
        int unsigned base;
        case (idx % NOTE_PER_OCT)
            0:       base = 262;
            1:       base = 294;
            2:       base = 330;
            3:       base = 349;
            4:       base = 392;
            5:       base = 440;
            default: base = 494;
        endcase
        return base << (idx / NOTE_PER_OCT);
    endfunction

    // Clock cycles per square-wave half period; out-of-range notes map to 1.
    function automatic int unsigned half_period(input int unsigned clk_hz, input int unsigned idx);
        if (idx >= NOTE_CNT) begin
            return 1;
        end
        return clk_hz / (2 * note_hz(idx));
    endfunction

endpackage

// File: rtl/tone_voice.sv
// One square-wave voice: phase/duration counters and output level.
// TONE_SYNTH_RETRIG_EN adds a latched note and a match output for retrigger.
module tone_voice
    import tone_pkg::*;
#(
    parameter int unsigned HALF_W  = 17,
    parameter int unsigned DUR_W   = 24,
    parameter int unsigned DUR_CYC = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              retrig,
    input  logic [HALF_W-1:0] half,
`ifdef TONE_SYNTH_RETRIG_EN
    input  logic [NOTE_W-1:0] note_in,
    output logic              hit_c,
`endif
    output logic              busy,
    output logic              level
);

    localparam logic [DUR_W-1:0] DUR_LAST = DUR_W'(DUR_CYC - 1);

    logic [HALF_W-1:0] half_q;
    logic [HALF_W-1:0] phase;
    logic [DUR_W-1:0]  dur;

`ifdef TONE_SYNTH_RETRIG_EN
    logic [NOTE_W-1:0] note;

    // Latch the note at start so repeats of it can be recognised.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            note <= '0;
        end else if (start) begin
            note <= note_in;
        end
    end

    assign hit_c = busy & (note == note_in);
`endif

    // Square-wave phase, duration timer and busy/level state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            level  <= 1'b0;
            phase  <= '0;
            dur    <= '0;
            half_q <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            level  <= 1'b1;
            phase  <= '0;
            dur    <= '0;
            half_q <= half;
        end else if (busy) begin
            if (!retrig && (dur == DUR_LAST)) begin
                busy  <= 1'b0;
                level <= 1'b0;
                phase <= '0;
                dur   <= '0;
            end else begin
                dur <= retrig ? '0 : dur + DUR_W'(1);
                if (phase == half_q - HALF_W'(1)) begin
                    phase <= '0;
                    level <= ~level;
                end else begin
                    phase <= phase + HALF_W'(1);
                end
            end
        end
    end

endmodule

// File: rtl/tone_synth_poly.sv
// Polyphonic square-wave tone generator with sigma-delta 1-bit mixer.
// Optional feature macro: TONE_SYNTH_RETRIG_EN (repeat of an active note restarts it).
module tone_synth_poly
    import tone_pkg::*;
#(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned N_VOICES = 4,
    parameter int unsigned DUR_MS   = 200
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                note_valid,
    input  logic [NOTE_W-1:0]   note_idx,
    output logic                note_ready,
    output logic [N_VOICES-1:0] voice_busy,
    output logic                speaker
);

    localparam int unsigned DUR_CYC = (CLK_HZ / 1000) * DUR_MS;
    localparam int unsigned DUR_W   = $clog2(DUR_CYC + 1);
    localparam int unsigned HALF_W  = $clog2(half_period(CLK_HZ, 0) + 1);
    localparam int unsigned ACC_W   = $clog2(2 * N_VOICES);

    logic [HALF_W-1:0]   half_tab [NOTE_CNT];
    logic [HALF_W-1:0]   half_sel_c;
    logic                idx_ok_c;
    logic                accept_c;
    logic [N_VOICES-1:0] free_c;
    logic [N_VOICES-1:0] alloc_oh_c;
    logic [N_VOICES-1:0] start_c;
    logic [N_VOICES-1:0] retrig_c;
    logic [N_VOICES-1:0] level_v;
    logic [ACC_W-1:0]    sum_c;
    logic [ACC_W-1:0]    acc_next_c;
    logic [ACC_W-1:0]    acc;

    // Elaboration-time half-period table, one entry per note.
    for (genvar i = 0; i < NOTE_CNT; i++) begin : g_half
        assign half_tab[i] = HALF_W'(half_period(CLK_HZ, i));
    end

    assign idx_ok_c   = (note_idx < NOTE_W'(NOTE_CNT));
    assign free_c     = ~voice_busy;
    assign alloc_oh_c = free_c & (~free_c + N_VOICES'(1));
    assign accept_c   = note_valid & note_ready;

    // Half-period lookup for the requested note.
    always_comb begin
        half_sel_c = '0;
        if (idx_ok_c) begin
            half_sel_c = half_tab[note_idx];
        end
    end

`ifdef TONE_SYNTH_RETRIG_EN
    logic [N_VOICES-1:0] hit_c;
    logic [N_VOICES-1:0] match_c;
    logic [N_VOICES-1:0] match_oh_c;

    assign match_c    = hit_c & {N_VOICES{idx_ok_c}};
    assign match_oh_c = match_c & (~match_c + N_VOICES'(1));
    assign note_ready = rst_n & ((|free_c) | (|match_c));

    // Retrigger the lowest matching voice, else allocate the lowest free one.
    always_comb begin
        start_c  = '0;
        retrig_c = '0;
        if (accept_c && idx_ok_c) begin
            if (|match_c) begin
                retrig_c = match_oh_c;
            end else begin
                start_c = alloc_oh_c;
            end
        end
    end

    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        tone_voice #(
            .HALF_W (HALF_W),
            .DUR_W  (DUR_W),
            .DUR_CYC(DUR_CYC)
        ) u_voice (
            .clk    (clk),
            .rst_n  (rst_n),
            .start  (start_c[v]),
            .retrig (retrig_c[v]),
            .half   (half_sel_c),
            .note_in(note_idx),
            .hit_c  (hit_c[v]),
            .busy   (voice_busy[v]),
            .level  (level_v[v])
        );
    end
`else
    assign note_ready = rst_n & (|free_c);

    // Allocate the lowest free voice for every valid accepted note.
    always_comb begin
        start_c  = '0;
        retrig_c = '0;
        if (accept_c && idx_ok_c) begin
            start_c = alloc_oh_c;
        end
    end

    for (genvar v = 0; v < N_VOICES; v++) begin : g_voice
        tone_voice #(
            .HALF_W (HALF_W),
            .DUR_W  (DUR_W),
            .DUR_CYC(DUR_CYC)
        ) u_voice (
            .clk   (clk),
            .rst_n (rst_n),
            .start (start_c[v]),
            .retrig(retrig_c[v]),
            .half  (half_sel_c),
            .busy  (voice_busy[v]),
            .level (level_v[v])
        );
    end
`endif

    // Count voices currently driving high.
    always_comb begin
        sum_c = '0;
        for (int v = 0; v < N_VOICES; v++) begin
            sum_c = sum_c + ACC_W'(level_v[v] & voice_busy[v]);
        end
    end

    assign acc_next_c = acc + sum_c;

    // First-order sigma-delta: emit a 1 whenever the accumulator passes N_VOICES.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc     <= '0;
            speaker <= 1'b0;
        end else if (acc_next_c >= ACC_W'(N_VOICES)) begin
            acc     <= acc_next_c - ACC_W'(N_VOICES);
            speaker <= 1'b1;
        end else begin
            acc     <= acc_next_c;
            speaker <= 1'b0;
        end
    end

endmodule
